fifo_read_stream: RTL
=====================

// Module: fifo_read_stream
// PURPOSE
//  Read-side drain stage for the async FIFO. Pops words into a 2-entry skid buffer and presents
//  them as a valid/ready stream with burst framing (m_last every BURST_LEN beats). Sits in the
//  read_clk domain, directly downstream of the FIFO's read port.
//  Registered outputs, no combinational ready->read_en path.
// PARAMETERS
//  WIDTH      32  data width; must match the FIFO
//  BURST_LEN  4   beats per burst, >=1; m_last marks the final beat
// PORTS
//  read_clk      in   1          single clock (FIFO read domain)
//  read_reset_n  in   1          async assert, active-low; deassertion pre-synchronised to read_clk
//  fifo_empty    in   1          FIFO empty flag
//  fifo_data     in   WIDTH      FIFO head word; valid whenever !fifo_empty
//  fifo_read_en  out  1          pop request to FIFO
//  m_valid       out  1          output beat valid
//  m_ready       in   1          downstream accept
//  m_data        out  WIDTH      output beat data
//  m_last        out  1          final beat of current burst
// BEHAVIOUR
//  Reset (read_reset_n=0, async): occupancy=EMPTY, beat_cnt=0, m_valid=0, m_data=0, m_last=0,
//   fifo_read_en=0. Reset mid-burst discards buffered words; the next accepted beat is beat 0.
//  Occupancy FSM EMPTY/ONE/TWO; pop = fifo_read_en = !fifo_empty && occ!=TWO; take = m_valid && m_ready.
//   EMPTY: pop -> ONE (word into slot0)
//   ONE:   pop&take -> ONE (slot0 <= fifo_data); pop&!take -> TWO (slot1 <= fifo_data); take&!pop -> EMPTY
//   TWO:   take -> ONE (slot0 <= slot1); no pop while TWO
//  m_valid = occ!=EMPTY; m_data = slot0. Latency: word at FIFO head with fifo_empty=0 at edge N
//   appears on m_data after edge N (1 cycle). Sustains 1 beat/cycle with m_ready held high.
//  Hold rule: while m_valid && !m_ready, m_data and m_last are stable.
//  Framing: beat_cnt increments on take, wraps BURST_LEN-1 -> 0; m_last = (beat_cnt==BURST_LEN-1).
//   BURST_LEN=1: m_last is constant 1 whenever m_valid.
//  fifo_empty rising while occ=ONE: buffer drains normally, no spurious pop.
//  Never pops when fifo_empty=1; never overwrites an unaccepted slot.
// CONFIGURATION
//  FIFO_READ_STREAM_STATS_EN defined: adds outputs stat_beats[31:0] (takes) and
//   stat_stalls[15:0] (cycles with m_valid && !m_ready), both saturating, cleared by reset.
//  Not defined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  Shared package afifo_pkg: occupancy encoding localparams (OCC_EMPTY=2'd0, OCC_ONE=2'd1,
//   OCC_TWO=2'd2) and the default WIDTH constant shared with the FIFO.
//  One natural sub-module: skid_buffer_2 (2-slot buffer plus occupancy FSM); framing counter and
//   stats stay in the top.
// TESTING
//  1 Reset: hold read_reset_n=0 with fifo_empty=0 -> fifo_read_en=0, m_valid=0, m_data=0, m_last=0.
//  2 Streaming: 8 words 0x11..0x88, m_ready=1 -> 8 beats in order, 1/cycle,
//    m_last on beats 4 and 8 (BURST_LEN=4).
//  3 Backpressure: m_ready=0 for 5 cycles after first beat -> occ=TWO, fifo_read_en=0,
//    m_data holds 0x11; release -> 0x22, 0x33 follow with no gap or loss.
//  4 Underrun: fifo_empty toggles every cycle, m_ready=1 -> no pop while empty,
//    data order preserved, m_valid drops only when buffer empty.
//  5 Reset mid-burst: reset after beat 2 of 4 -> buffer flushed; next accepted beat has m_last=0
//    and beat_cnt restarts at 0.
//  6 Stats (FIFO_READ_STREAM_STATS_EN): 10 beats, 3 stall cycles -> stat_beats=10, stat_stalls=3.

Source files
------------

// File: rtl/afifo_pkg.sv
// Shared definitions for the async FIFO and its read-side drain stage:
// the occupancy encoding of the 2-entry skid buffer and the default data width.
package afifo_pkg;

   localparam int DEFAULT_WIDTH = 32;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_TWO   = 2'd2;

   typedef enum logic [1:0] {
      S_EMPTY = OCC_EMPTY,
      S_ONE   = OCC_ONE,
      S_TWO   = OCC_TWO
   } occ_e;

   // Width of a counter that must hold 0..n-1; a single bit is kept even when n is 1
   function automatic int cntWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_read_stream_skid_buffer_2.sv
// skid_buffer_2: two-slot holding buffer between the FIFO read port and the
// valid/ready stream. slot0 is always the presented word; slot1 catches the word
// popped in the cycle the consumer stalled, so the pop decision never depends on
// the consumer's ready.
module skid_buffer_2
   import afifo_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rstN,
   input  logic             i_fifoEmpty,
   input  logic [WIDTH-1:0] i_fifoData,
   output logic             o_fifoReadEn,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data
);

   occ_e             r_occ;
   logic             r_valid;
   logic [WIDTH-1:0] r_slot0;
   logic [WIDTH-1:0] r_slot1;
   logic             w_pop;
   logic             w_take;

   // Pop whenever the FIFO has a word and a slot is guaranteed free; reset gates it
   // so nothing is requested from the FIFO while this stage is being held in reset
   assign w_pop        = i_rstN && !i_fifoEmpty && (r_occ != S_TWO);
   assign w_take       = r_valid && i_ready;
   assign o_fifoReadEn = w_pop;
   assign o_valid      = r_valid;
   assign o_data       = r_slot0;

   // Occupancy FSM: moves words into slot0/slot1 and keeps valid registered with the state
   always_ff @(posedge i_clk or negedge i_rstN) begin
      if (!i_rstN) begin
         r_occ   <= S_EMPTY;
         r_valid <= 1'b0;
         r_slot0 <= '0;
         r_slot1 <= '0;
      end else begin
         case (r_occ)
            S_EMPTY: begin
               if (w_pop) begin
                  r_slot0 <= i_fifoData;
                  r_occ   <= S_ONE;
                  r_valid <= 1'b1;
               end
            end
            S_ONE: begin
               if (w_pop && w_take) begin
                  r_slot0 <= i_fifoData;
               end else if (w_pop) begin
                  r_slot1 <= i_fifoData;
                  r_occ   <= S_TWO;
               end else if (w_take) begin
                  r_occ   <= S_EMPTY;
                  r_valid <= 1'b0;
               end
            end
            S_TWO: begin
               if (w_take) begin
                  r_slot0 <= r_slot1;
                  r_occ   <= S_ONE;
               end
            end
            default: begin
               r_occ   <= S_EMPTY;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/fifo_read_stream.sv
// fifo_read_stream: read-side drain stage of the async FIFO. Pops words through a
// 2-slot skid buffer and presents them as a valid/ready stream, marking every
// BURST_LEN-th accepted beat with m_last.
// Optional build macro FIFO_READ_STREAM_STATS_EN adds saturating beat and stall
// counters (stat_beats, stat_stalls).
module fifo_read_stream
   import afifo_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int BURST_LEN = 4
) (
   input  logic             read_clk,
   input  logic             read_reset_n,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             fifo_read_en,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
`ifdef FIFO_READ_STREAM_STATS_EN
   output logic             m_last,
   output logic [31:0]      stat_beats,
   output logic [15:0]      stat_stalls
`else
   output logic             m_last
`endif
);

   localparam int               CNT_W     = cntWidth(BURST_LEN);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

   logic             w_valid;
   logic             w_take;
   logic [CNT_W-1:0] r_beatCnt;

   skid_buffer_2 #(
      .WIDTH (WIDTH)
   ) u_skid (
      .i_clk        (read_clk),
      .i_rstN       (read_reset_n),
      .i_fifoEmpty  (fifo_empty),
      .i_fifoData   (fifo_data),
      .o_fifoReadEn (fifo_read_en),
      .o_valid      (w_valid),
      .i_ready      (m_ready),
      .o_data       (m_data)
   );

   assign w_take  = w_valid && m_ready;
   assign m_valid = w_valid;
   // The beat counter only moves on an accepted beat, so m_last holds during a stall
   assign m_last  = w_valid && (r_beatCnt == LAST_BEAT);

   // Burst position: counts accepted beats and wraps at the end of each burst
   always_ff @(posedge read_clk or negedge read_reset_n) begin
      if (!read_reset_n) begin
         r_beatCnt <= '0;
      end else if (w_take) begin
         if (r_beatCnt == LAST_BEAT) begin
            r_beatCnt <= '0;
         end else begin
            r_beatCnt <= r_beatCnt + CNT_W'(1);
         end
      end
   end

`ifdef FIFO_READ_STREAM_STATS_EN
   logic [31:0] r_statBeats;
   logic [15:0] r_statStalls;

   assign stat_beats  = r_statBeats;
   assign stat_stalls = r_statStalls;

   // Saturating counters of accepted beats and of cycles the consumer held off a valid beat
   always_ff @(posedge read_clk or negedge read_reset_n) begin
      if (!read_reset_n) begin
         r_statBeats  <= '0;
         r_statStalls <= '0;
      end else begin
         if (w_take && (r_statBeats != '1)) begin
            r_statBeats <= r_statBeats + 32'd1;
         end
         if (w_valid && !m_ready && (r_statStalls != '1)) begin
            r_statStalls <= r_statStalls + 16'd1;
         end
      end
   end
`endif

endmodule
